// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the two requesters (ALU, memory load) and the
// register-file write arbiter. The master side is the requester/register-file
// pair. The slave side is the arbiter itself.
interface regfile_write_arbiter_if #(
    parameter int STALL_W = 16
);
    // Request A: ALU writeback
    logic                reqA_valid;
    logic [4:0]          reqA_reg;
    logic [31:0]         reqA_data;
    logic                reqA_ready;

    // Request B: memory-load writeback
    logic                reqB_valid;
    logic [4:0]          reqB_reg;
    logic [31:0]         reqB_data;
    logic                reqB_ready;

    // Registered register-file write port and status
    logic                RegWrite;
    logic [4:0]          writeReg;
    logic [31:0]         writeData;
    logic                initDone;
    logic [STALL_W-1:0]  conflictCount;

    modport master (
        output reqA_valid, reqA_reg, reqA_data,
        output reqB_valid, reqB_reg, reqB_data,
        input  reqA_ready, reqB_ready,
        input  RegWrite, writeReg, writeData, initDone, conflictCount
    );

    modport slave (
        input  reqA_valid, reqA_reg, reqA_data,
        input  reqB_valid, reqB_reg, reqB_data,
        output reqA_ready, reqB_ready,
        output RegWrite, writeReg, writeData, initDone, conflictCount
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter.
// Merges the ALU (A) and memory-load (B) writeback streams onto one registered
// write port. After reset it can optionally zero-fill registers 1..31. It also
// counts the cycles where a tie forced one requester to wait.
//
// Optional feature macro: REGARB_ROUND_ROBIN_EN
//   defined   -> round-robin tie-break (the last winner loses the next tie)
//   undefined -> fixed priority (A always wins ties)
module regfile_write_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int STALL_W        = 16
) (
    input  logic                     CLK,
    input  logic                     Reset_L,
    regfile_write_arbiter_if.slave   bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    state_t              state;
    logic [4:0]          idx;
    logic                init_done;
    logic [STALL_W-1:0]  conflicts;
    logic                reg_write;
    logic [4:0]          write_reg;
    logic [31:0]         write_data;

    logic                tie;
    logic                grant_a;
    logic                grant_b;
    logic                accept_a;
    logic                accept_b;

`ifdef REGARB_ROUND_ROBIN_EN
    // Set when A won the most recent grant, so B is favoured on the next tie.
    logic                favor_b;

    // Round-robin pointer: track the last granted requester.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            favor_b <= 1'b0;
        end else if (accept_a) begin
            favor_b <= 1'b1;
        end else if (accept_b) begin
            favor_b <= 1'b0;
        end
    end

    // Tie-break: the requester that won last waits when both are valid.
    always_comb begin
        tie     = bus.reqA_valid && bus.reqB_valid;
        grant_a = bus.reqA_valid && !(tie && favor_b);
        grant_b = bus.reqB_valid && !grant_a;
    end
`else
    // Fixed priority: A wins every tie and B waits.
    always_comb begin
        tie     = bus.reqA_valid && bus.reqB_valid;
        grant_a = bus.reqA_valid;
        grant_b = bus.reqB_valid && !grant_a;
    end
`endif

    // init_done is only set in ARB, so it also blocks acceptance during CLEAR.
    // A held request simply waits there until the fill completes.
    always_comb begin
        accept_a = init_done && grant_a;
        accept_b = init_done && grant_b;
    end

    // Control FSM and registered write port. In CLEAR it zero-fills r1..r31.
    // In ARB it forwards the accepted request one cycle later.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= CLEAR_ON_RESET ? CLEAR : ARB;
            idx        <= 5'd1;
            init_done  <= 1'b0;
            conflicts  <= '0;
            reg_write  <= 1'b0;
            write_reg  <= 5'd0;
            write_data <= 32'd0;
        end else begin
            case (state)
                CLEAR: begin
                    reg_write  <= 1'b1;
                    write_reg  <= idx;
                    write_data <= 32'd0;
                    if (idx == 5'd31) begin
                        state <= ARB;
                    end else begin
                        idx <= idx + 5'd1;
                    end
                end
                default: begin
                    init_done <= 1'b1;
                    // r0 is hard-wired: accept the request but suppress the strobe
                    if (accept_a) begin
                        reg_write  <= (bus.reqA_reg != 5'd0);
                        write_reg  <= bus.reqA_reg;
                        write_data <= bus.reqA_data;
                    end else if (accept_b) begin
                        reg_write  <= (bus.reqB_reg != 5'd0);
                        write_reg  <= bus.reqB_reg;
                        write_data <= bus.reqB_data;
                    end else begin
                        reg_write  <= 1'b0;
                    end
                    // A tie always refuses one side. Saturate instead of wrapping.
                    if (init_done && tie && (conflicts != {STALL_W{1'b1}})) begin
                        conflicts <= conflicts + STALL_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.reqA_ready    = accept_a;
    assign bus.reqB_ready    = accept_b;
    assign bus.RegWrite      = reg_write;
    assign bus.writeReg      = write_reg;
    assign bus.writeData     = write_data;
    assign bus.initDone      = init_done;
    assign bus.conflictCount = conflicts;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter (default fixed-priority build).
// The stimulus process pushes expected writes. The negedge monitor pops and
// compares every cycle in which RegWrite is high.
module tb_regfile_write_arbiter;
    localparam int SW = 4;

    logic CLK = 1'b0;
    logic Reset_L = 1'b0;
    always #5 CLK = ~CLK;

    regfile_write_arbiter_if #(.STALL_W(SW)) bus ();
    regfile_write_arbiter_if #(.STALL_W(SW)) bus0 ();

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b1), .STALL_W(SW)) dut (
        .CLK(CLK), .Reset_L(Reset_L), .bus(bus.slave));

    regfile_write_arbiter #(.CLEAR_ON_RESET(1'b0), .STALL_W(SW)) dut0 (
        .CLK(CLK), .Reset_L(Reset_L), .bus(bus0.slave));

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wr_t w;
        w.r = r;
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic push_clear();
        for (int i = 1; i < 32; i++) push(5'(i), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_regwrite"}, bus.RegWrite, 0);
        chk({tag, "_writereg"}, bus.writeReg, 0);
        chk({tag, "_writedata"}, bus.writeData, 0);
        chk({tag, "_readyA"}, bus.reqA_ready, 0);
        chk({tag, "_readyB"}, bus.reqB_ready, 0);
        chk({tag, "_initdone"}, bus.initDone, 0);
        chk({tag, "_conflicts"}, bus.conflictCount, 0);
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge CLK) begin
        if (Reset_L && bus.RegWrite) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data %0h, expected no write",
                         bus.writeReg, bus.writeData);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_writereg", bus.writeReg, mon_e.r);
                chk("sb_writedata", bus.writeData, mon_e.d);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd1; bus.reqA_data = 32'h1;
        bus.reqB_valid = 1'b1; bus.reqB_reg = 5'd2; bus.reqB_data = 32'h2;
        bus0.reqA_valid = 1'b0; bus0.reqA_reg = '0; bus0.reqA_data = '0;
        bus0.reqB_valid = 1'b0; bus0.reqB_reg = '0; bus0.reqB_data = '0;

        // Reset values, with requests pending
        repeat (3) @(posedge CLK);
        #1 chk_reset_outputs("rst");
        bus.reqA_valid = 1'b0;
        bus.reqB_valid = 1'b0;

        // Zero-fill: 31 writes, initDone on cycle 32
        push_clear();
        @(posedge CLK); #2 Reset_L = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(posedge CLK); #1;
            if (c == 1) chk("noclear_initdone", bus0.initDone, 1);
            if (c == 1) chk("noclear_regwrite", bus0.RegWrite, 0);
            if (c == 31) chk("initdone_at31", bus.initDone, 0);
            if (c == 32) begin
                chk("initdone_at32", bus.initDone, 1);
                chk("regwrite_at32", bus.RegWrite, 0);
            end
        end
        @(negedge CLK); #1 chk("clear_drained", exp_q.size(), 0);

        // Single A write
        @(negedge CLK);
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd5; bus.reqA_data = 32'h1234;
        #1 chk("single_readyA", bus.reqA_ready, 1);
        push(5'd5, 32'h1234);
        @(posedge CLK); #1 bus.reqA_valid = 1'b0;

        // r0 write is accepted but never strobed
        @(negedge CLK);
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd0; bus.reqA_data = 32'hFFFF;
        #1 chk("r0_readyA", bus.reqA_ready, 1);
        @(posedge CLK); #1 bus.reqA_valid = 1'b0;
        chk("r0_regwrite", bus.RegWrite, 0);

        // Tie: A first, then B, one conflict
        @(negedge CLK);
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd3; bus.reqA_data = 32'd7;
        bus.reqB_valid = 1'b1; bus.reqB_reg = 5'd4; bus.reqB_data = 32'd9;
        #1 chk("tie_readyA", bus.reqA_ready, 1);
        chk("tie_readyB", bus.reqB_ready, 0);
        push(5'd3, 32'd7);
        @(posedge CLK); #1 bus.reqA_valid = 1'b0;
        #1 chk("tie2_readyB", bus.reqB_ready, 1);
        chk("tie_conflicts", bus.conflictCount, 1);
        push(5'd4, 32'd9);
        @(posedge CLK); #1 bus.reqB_valid = 1'b0;
        chk("tie_conflicts_after", bus.conflictCount, 1);

        // Same destination: both writes land, in grant order
        @(negedge CLK);
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd6; bus.reqA_data = 32'h11;
        bus.reqB_valid = 1'b1; bus.reqB_reg = 5'd6; bus.reqB_data = 32'h22;
        push(5'd6, 32'h11);
        @(posedge CLK); #1 bus.reqA_valid = 1'b0;
        push(5'd6, 32'h22);
        @(posedge CLK); #1 bus.reqB_valid = 1'b0;
        chk("same_conflicts", bus.conflictCount, 2);

        // 2^SW+3 tie cycles: counter saturates at all-ones
        @(negedge CLK);
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd0; bus.reqA_data = 32'h5;
        bus.reqB_valid = 1'b1; bus.reqB_reg = 5'd8; bus.reqB_data = 32'h55;
        repeat ((1 << SW) + 3) @(posedge CLK);
        #1 chk("sat_conflicts", bus.conflictCount, 4'hF);
        chk("sat_readyB", bus.reqB_ready, 0);
        bus.reqA_valid = 1'b0;
        bus.reqB_valid = 1'b0;
        @(posedge CLK); #1 chk("sat_hold", bus.conflictCount, 4'hF);

        // Reset in ARB, then pulse reset again at CLEAR idx=10
        @(posedge CLK); #2 Reset_L = 1'b0;
        repeat (2) @(posedge CLK);
        #2 push_clear();
        Reset_L = 1'b1;
        repeat (9) @(posedge CLK);
        #1 chk("mid_writereg9", bus.writeReg, 9);
        chk("mid_regwrite", bus.RegWrite, 1);
        #1 Reset_L = 1'b0;
        #1 chk_reset_outputs("midclear");
        chk("mid_pending", exp_q.size(), 23);
        exp_q.delete();

        // Refill restarts at r1; A request is held through CLEAR
        bus.reqA_valid = 1'b1; bus.reqA_reg = 5'd7; bus.reqA_data = 32'hAA;
        repeat (2) @(posedge CLK);
        #2 push_clear();
        Reset_L = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK); #1;
            if (i == 0) chk("hold_ready_clear", bus.reqA_ready, 0);
            if (bus.reqA_ready) begin
                seen = 1'b1;
                chk("hold_accept_cycle", i, 32);
                break;
            end
        end
        chk("hold_seen", seen, 1);
        if (seen) push(5'd7, 32'hAA);
        @(posedge CLK); #1 bus.reqA_valid = 1'b0;
        repeat (2) @(negedge CLK);
        #1 chk("final_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL take parameter CLEAR_ON_RESET, default 1: 1 = zero-fill registers 1..31 after reset; 0 = skip the fill.
REQ-002 The block SHALL take parameter STALL_W, default 16: width of the saturating conflict counter.
REQ-003 Port CLK  input  1  single clock; all state changes on posedge.
REQ-004 Port Reset_L  input  1  asynchronous, active-low reset.
REQ-005 Port reqA_valid / reqA_reg / reqA_data  input  1/5/32  ALU writeback request: valid, destination, data.
REQ-006 Port reqA_ready  output  1  request A accepted this cycle.
REQ-007 Port reqB_valid / reqB_reg / reqB_data  input  1/5/32  memory-load writeback request: valid, destination, data.
REQ-008 Port reqB_ready  output  1  request B accepted this cycle.
REQ-009 Port RegWrite / writeReg / writeData  output  1/5/32  register-file write port, registered.
REQ-010 Port initDone  output  1  high once the zero-fill is complete, or immediately after reset when CLEAR_ON_RESET=0.
REQ-011 Port conflictCount  output  STALL_W  number of cycles in which both requests were valid and one was refused.

Function
REQ-012 The FSM SHALL have states CLEAR and ARB; reset enters CLEAR if CLEAR_ON_RESET=1, otherwise ARB.
REQ-013 CLEAR SHALL drive RegWrite=1, writeData=0 and writeReg=idx, with idx stepping 1..31 one per cycle; after idx=31 is issued, the FSM moves to ARB and initDone rises in the following cycle (31 write cycles in total).
REQ-014 In CLEAR, reqA_ready and reqB_ready SHALL be 0, and valid requests are held, not dropped.
REQ-015 In ARB, a ready output SHALL be combinational: readyX = initDone && reqX_valid && grantX.
REQ-016 A handshake SHALL complete when valid&&ready are both high at posedge; the requester holds reg/data stable until then.
REQ-017 An accepted request SHALL appear on RegWrite/writeReg/writeData in the next cycle (latency 1), held for exactly one cycle.
REQ-018 With no acceptance in a cycle, RegWrite SHALL be 0 in the next cycle, and writeReg/writeData hold their last values.
REQ-019 Only one request SHALL be granted per cycle; with both valid, the loser's ready is 0 and conflictCount increments.
REQ-020 conflictCount SHALL saturate at all-ones and never wrap.
REQ-021 A request with reg=0 SHALL be accepted normally, but the resulting cycle drives RegWrite=0, so register 0 is never written.
REQ-022 When both requests target the same register, the later-issued write SHALL be the last one applied; no merging or dropping occurs.
REQ-023 Outputs SHALL change only on posedge CLK, so they are stable at the negedge where the register file samples them.

Reset
REQ-024 While Reset_L=0, outputs SHALL be: RegWrite=0, writeReg=0, writeData=0, ready outputs=0, initDone=0, conflictCount=0, idx=1.
REQ-025 Reset asserted mid-CLEAR or mid-ARB SHALL abort immediately; after release, the zero-fill restarts from idx=1.
REQ-026 A transfer already registered on the write port SHALL be discarded when reset asserts; no partial write follows.

Configuration
REQ-027 Macro REGARB_ROUND_ROBIN_EN defined: arbitration is round-robin; the last-granted requester loses the next tie; the pointer resets to favour A.
REQ-028 Macro REGARB_ROUND_ROBIN_EN undefined: fixed priority; A always wins ties and B waits.

Verification
REQ-029 Reset release, CLEAR_ON_RESET=1, no requests -> writes reg1..reg31 = 0 on 31 consecutive cycles; initDone=1 on cycle 32; RegWrite=0 afterwards.
REQ-030 After init, A valid reg=5 data=0x1234 for one cycle -> reqA_ready=1; next cycle RegWrite=1, writeReg=5, writeData=0x1234.
REQ-031 A (reg=3, data=7) and B (reg=4, data=9) valid together for 2 cycles, fixed priority -> A written first, B second, conflictCount=1; round-robin repeating the tie -> grants alternate A,B,A.
REQ-032 A valid reg=0 data=0xFFFF -> reqA_ready=1 and RegWrite stays 0 in the next cycle.
REQ-033 Reset_L pulsed low at CLEAR idx=10 -> all outputs return to reset values at once; after release, the fill restarts at reg1.
REQ-034 Force 2^STALL_W+3 tie cycles -> conflictCount holds all-ones with no wrap.
